fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage: owns the PC, issues word reads to instruction memory, and feeds fetched instructions to `decoder` through a valid/ready interface.
- `o_opcode` drives `decoder.i_opcode_in`.
- Contains a 2-entry instruction buffer so memory latency and decode stalls are decoupled.
- Accepts PC redirects (branch/jump) from execute and discards stale work.

Parameters:
- RESET_VECTOR, 32'h00000000, PC loaded on reset.
- NOP_WORD, 32'h00000013, opcode presented while the buffer is empty (addi x0,x0,0).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- o_imem_addr  out  32  instruction memory word address (bits [1:0] always 00)
- o_imem_req  out  1  read request
- i_imem_ack  in  1  request accepted; i_imem_data valid this cycle
- i_imem_data  in  32  instruction word
- i_redirect  in  1  load new PC, flush
- i_redirect_pc  in  32  redirect target (bits [1:0] ignored)
- o_opcode  out  32  instruction at buffer head, to decoder
- o_pc  out  32  PC of o_opcode
- o_valid  out  1  buffer head valid
- i_ready  in  1  downstream accepts head this cycle

Behaviour:
- One clock (i_clk), reset synchronous active-high (i_rst).
- Reset (cycle i_rst high):
  - pc = RESET_VECTOR, buffer count = 0, state = FETCH.
  - o_imem_req = 0, o_valid = 0, o_opcode = NOP_WORD, o_pc = 0.
  - Reset mid-transaction abandons it; the memory must tolerate request withdrawal on reset.
- Memory handshake:
  - o_imem_req and o_imem_addr are held stable from assertion until the cycle with i_imem_ack=1.
  - Ack may arrive in the same cycle as req (zero-wait).
  - At most one outstanding request.
- FSM states: FETCH, DROP.
- FETCH:
  - o_imem_req = (count < 2) and not i_rst; o_imem_addr = pc.
  - Once raised, req stays high until ack, because count cannot rise without ack.
  - On ack without redirect: push {pc, i_imem_data}; pc <= pc + 4 (wraps 0xFFFFFFFC -> 0).
- Redirect (priority over push and pop):
  - Buffer flushed (count <= 0); o_valid low next cycle.
  - pc <= {i_redirect_pc[31:2], 2'b00}.
  - If req is high and ack is low this cycle, go to DROP and latch the new pc. Otherwise stay in FETCH; an ack in the same cycle is discarded.
- DROP:
  - o_imem_req held high with the old address until ack.
  - The acked data is discarded; then go to FETCH using the latched pc.
  - A further redirect in DROP overwrites the latched pc and stays in DROP.
- Buffer:
  - 2-entry FIFO holding {pc, instruction}.
  - Pop when o_valid & i_ready.
  - Push and pop in the same cycle leave count unchanged.
  - o_valid = (count != 0). o_opcode / o_pc come from the head; NOP_WORD / 0 when empty.
- Timing:
  - With zero-wait memory: latency from request to o_valid is 1 cycle.
  - Sustained throughput is 1 instruction/cycle with i_ready held high.
- Stall: with i_ready low, the head holds stable; after 2 entries req drops and pc holds.
- All outputs except o_imem_req/o_imem_addr are registered or derived from registered state.
- o_imem_req is combinational from state/count; no combinational path from i_imem_ack to o_imem_req.

Test Plan:
- Reset release, zero-wait memory returning addr^32'hA5A5A5A5, i_ready=1:
  - Req at addr 0 in the first cycle; o_valid=1 from the next cycle with o_pc=0, o_opcode=32'hA5A5A5A5.
  - o_pc then increments 0, 4, 8 each cycle.
- Memory with 3-cycle ack latency:
  - o_imem_addr is stable across the wait.
  - One instruction is delivered every 3 cycles with correct o_pc.
  - Req is never re-issued before ack.
- i_ready=0 for 6 cycles from start:
  - count saturates at 2 (o_pc 0 held); o_imem_req deasserts; pc=8.
  - On i_ready=1, PCs 0, 4, 8 appear in order with no gap or duplicate.
- Redirect to 32'h00000103 while buffer holds 2 entries and a request is mid-wait:
  - Next cycle o_valid=0, state DROP, old addr held until ack.
  - The stale data never appears; next request addr = 32'h00000100.
- Redirect in the same cycle as ack:
  - Acked word dropped; the next cycle requests the target address directly (no DROP).
- PC wrap and mid-operation reset:
  - Redirect to 32'hFFFFFFFC gives the following fetch at 0.
  - Asserting i_rst during DROP returns o_valid=0, o_imem_req=0, and next fetch addr RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads and
// buffers up to two {pc, insn} entries for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic {FETCH, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [1:0]  cnt_q, cnt_d;
  entry_t      e0_q, e0_d;
  entry_t      e1_q, e1_d;
  entry_t      new_e;
  logic [31:0] rd_pc;
  logic        push;
  logic        pop;

  assign rd_pc = i_redirect_pc & ~32'h3;
  assign new_e = '{pc: pc_q, insn: i_imem_data};

  // DROP keeps the stale request alive until memory acks it.
  assign o_imem_req = !i_rst &&
    ((state_q == DROP) || (cnt_q != 2'd2));
  assign o_imem_addr = pc_q;

  assign o_valid  = (cnt_q != 2'd0);
  assign o_opcode = o_valid ? e0_q.insn : NOP_WORD;
  assign o_pc     = o_valid ? e0_q.pc : 32'h0;

  assign push = (state_q == FETCH) && o_imem_req &&
    i_imem_ack && !i_redirect;
  assign pop = o_valid && i_ready && !i_redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    e0_d    = e0_q;
    e1_d    = e1_q;

    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) e0_d = new_e;
        else               e1_d = new_e;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        e0_d  = e1_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = new_e;
        end else begin
          e0_d = e1_q;
          e1_d = new_e;
        end
      end
      default: ;
    endcase

    if (push) pc_d = pc_q + 32'd4;

    unique case (state_q)
      FETCH: begin
        if (i_redirect) begin
          cnt_d = 2'd0;
          if (o_imem_req && !i_imem_ack) begin
            state_d = DROP;
            tgt_d   = rd_pc;
          end else begin
            pc_d = rd_pc;
          end
        end
      end
      DROP: begin
        cnt_d = 2'd0;
        if (i_imem_ack) begin
          state_d = FETCH;
          pc_d    = i_redirect ? rd_pc : tgt_q;
        end else if (i_redirect) begin
          tgt_d = rd_pc;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= RESET_VECTOR;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule
